omsp_spm_key_loader: RTL and testbench
======================================

# omsp_spm_key_loader

Sequencer that streams a freshly derived module key into the protected-module array one 16-bit word at a time. Sits directly upstream of the SPM control block and drives its `write_key`, `key_in` and `key_idx` inputs. It consumes words from the key-derivation engine over a valid/ready handshake and watches `spm_key_select_valid`, so a key is only ever written into a selected, enabled module. Reports completion or one of three error causes to the Sancus instruction sequencer.

## Interface
- `KEY_IDX_SIZE`, default 3: width of the `key_idx` word index.
- `KEY_WORDS`, default 8: number of 16-bit words per key; equals `SECURITY`/16, and must be ≤ 2^`KEY_IDX_SIZE`.
- `TIMEOUT`, default 255: maximum number of idle LOAD cycles tolerated between source handshakes; range 1–255.

Ports:
- `mclk`  in  1  system clock; the only clock.
- `puc_rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle request to load a key into the currently key-selected module.
- `abort`  in  1  cancels an in-progress load.
- `spm_key_select_valid`  in  1  a module is selected by `spm_key_select`.
- `src_valid`  in  1  `src_data` is valid.
- `src_data`  in  16  key word from the derivation engine.
- `src_ready`  out  1  loader accepts `src_data` this cycle.
- `write_key`  out  1  write strobe into the module key register.
- `key_in`  out  16  key word being written.
- `key_idx`  out  `KEY_IDX_SIZE`  word index being written.
- `busy`  out  1  a load is in progress.
- `done`  out  1  one-cycle pulse on successful completion.
- `error`  out  1  one-cycle pulse on failure.
- `err_code`  out  2  failure cause: 01 no module selected, 10 timeout, 11 abort or deselect. Holds its value until the next `start`.

## Operation
- States: IDLE, CHECK, LOAD, FLUSH.
- IDLE:
  - On `start`, go to CHECK and clear `err_code`.
  - `start` in any other state is ignored.
- CHECK (1 cycle):
  - If `spm_key_select_valid`, go to LOAD with word counter = 0 and idle counter = 0.
  - Otherwise return to IDLE, pulse `error`, and set `err_code` = 01.
- LOAD:
  - `src_ready` = `spm_key_select_valid` & ~`abort` (combinational).
  - A handshake (`src_valid` & `src_ready`) registers `key_in` = `src_data` and `key_idx` = counter, and asserts `write_key` in the next cycle.
  - Each handshake increments the counter and clears the idle counter.
  - The handshake with counter = `KEY_WORDS`-1 moves the FSM to FLUSH.
- FLUSH (1 cycle):
  - `write_key` is high for the last word and `src_ready` = 0.
  - Then return to IDLE and pulse `done` in that cycle.
- Idle counter (8 bits): increments on each LOAD cycle without a handshake. On reaching `TIMEOUT`, go to IDLE, pulse `error`, and set `err_code` = 10.
- In LOAD or FLUSH, `abort`=1 or `spm_key_select_valid`=0:
  - Go to IDLE, pulse `error` next cycle, and set `err_code` = 11.
  - No handshake is accepted in that cycle.
  - A `write_key` already registered from the previous cycle still completes. The module key is then partial; the sequencer must treat `error` as fatal for that module.
- Simultaneous events:
  - `abort` beats a handshake.
  - A handshake in the same cycle the idle counter reaches `TIMEOUT` is accepted, and the timeout is cancelled.
  - Deselect beats everything.
- `busy` = state ≠ IDLE.
- Word order: `key_idx` 0 carries key bits [0:15] (MSB-first), and index i carries bits [16i:16i+15].

## Timing
- Reset:
  - State is IDLE.
  - `write_key`, `src_ready`, `busy`, `done`, `error` are all 0.
  - `key_in` = 16'h0, `key_idx` = 0, `err_code` = 2'b00, counters = 0.
- Reset asserted mid-load forces IDLE immediately. No `done` or `error` pulse is generated for the interrupted load.
- `start` at cycle t:
  - CHECK at t+1.
  - LOAD (first possible handshake) at t+2.
- Handshake at cycle c gives `write_key` at c+1.
- Back-to-back source:
  - 8 handshakes at t+2..t+9.
  - `write_key` at t+3..t+10; FLUSH at t+10.
  - `done` at t+11.
  - Total latency from `start` to `done` is `KEY_WORDS`+3 cycles.
- `error` and `done` pulse for exactly 1 cycle and are mutually exclusive.

## Test plan
- Key-selected module present; `start`; `src_valid` held high with words 16'h1111..16'h8888 → `write_key` high 8 consecutive cycles with `key_idx` 0..7 carrying those words; `done` 11 cycles after `start`; `error` never asserted.
- Same load with `src_valid` low for 3 cycles after word 4 → `write_key` gap of 3 cycles; indices stay contiguous; `done` at 14 cycles.
- `start` with `spm_key_select_valid`=0 → `error` at t+2, `err_code`=01, `write_key` never asserted.
- `TIMEOUT`=10; 2 words delivered, then `src_valid` held low → `error` with `err_code`=10 exactly 10 idle cycles after the second handshake; `busy` low the following cycle.
- `abort` in the same cycle as the handshake for word 5 → word 5 not written, `write_key` for word 4 still seen, `err_code`=11; a later `start` completes a normal 8-word load.
- `start` pulsed during LOAD → ignored, load unaffected; `puc_rst_n` low mid-load → all outputs return to reset values asynchronously, no `done`/`error` pulse.

Source files
------------

// File: rtl/omsp_spm_key_loader_if.sv
// Key-word stream from the key-derivation engine into the SPM key loader.
// The derivation engine is the master; the loader is the slave that
// answers with src_ready.
interface omsp_spm_key_loader_if;
    logic        src_valid;
    logic [15:0] src_data;
    logic        src_ready;

    modport master (
        output src_valid,
        output src_data,
        input  src_ready
    );

    modport slave (
        input  src_valid,
        input  src_data,
        output src_ready
    );
endinterface

// File: rtl/omsp_spm_key_loader.sv
// Streams a freshly derived module key into the protected-module array one
// 16-bit word at a time. Words arrive over a valid/ready handshake and are
// re-issued one cycle later on write_key/key_in/key_idx. A load only
// proceeds while a module is selected. It reports done, or an error with a
// cause code: no module selected, source timeout, or abort/deselect.
module omsp_spm_key_loader #(
    parameter int KEY_IDX_SIZE = 3,
    parameter int KEY_WORDS    = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                    mclk,
    input  logic                    puc_rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    spm_key_select_valid,
    omsp_spm_key_loader_if.slave    src,
    output logic                    write_key,
    output logic [15:0]             key_in,
    output logic [KEY_IDX_SIZE-1:0] key_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              err_code
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_LOAD  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam logic [KEY_IDX_SIZE-1:0] LAST_IDX  = KEY_IDX_SIZE'(KEY_WORDS - 1);
    localparam logic [7:0]              IDLE_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NOSEL   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [KEY_IDX_SIZE-1:0] r_word_cnt;
    logic [7:0]              r_idle_cnt;
    logic                    r_write_key;
    logic [15:0]             r_key_in;
    logic [KEY_IDX_SIZE-1:0] r_key_idx;
    logic                    r_done;
    logic                    r_error;
    logic [1:0]              r_err_code;

    logic                    w_src_ready;
    logic                    w_handshake;
    logic                    w_start_load;
    logic                    w_set_done;
    logic                    w_set_error;
    logic                    w_load_err;
    logic [1:0]              w_err_val;

    // State register; reset drops any load in flight straight back to IDLE.
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and per-cycle decisions. Deselect and abort take priority
    // over a handshake. A handshake takes priority over the idle timeout.
    always_comb begin
        w_next_state = r_state;
        w_src_ready  = 1'b0;
        w_handshake  = 1'b0;
        w_start_load = 1'b0;
        w_set_done   = 1'b0;
        w_set_error  = 1'b0;
        w_load_err   = 1'b0;
        w_err_val    = ERR_NONE;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_CHECK;
                    w_load_err   = 1'b1;
                    w_err_val    = ERR_NONE;
                end
            end
            S_CHECK: begin
                if (spm_key_select_valid) begin
                    w_next_state = S_LOAD;
                    w_start_load = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                    w_set_error  = 1'b1;
                    w_load_err   = 1'b1;
                    w_err_val    = ERR_NOSEL;
                end
            end
            S_LOAD: begin
                if (!spm_key_select_valid || abort) begin
                    w_next_state = S_IDLE;
                    w_set_error  = 1'b1;
                    w_load_err   = 1'b1;
                    w_err_val    = ERR_ABORT;
                end else begin
                    w_src_ready = 1'b1;
                    if (src.src_valid) begin
                        w_handshake = 1'b1;
                        if (r_word_cnt == LAST_IDX) begin
                            w_next_state = S_FLUSH;
                        end
                    end else if (r_idle_cnt == IDLE_LAST) begin
                        w_next_state = S_IDLE;
                        w_set_error  = 1'b1;
                        w_load_err   = 1'b1;
                        w_err_val    = ERR_TIMEOUT;
                    end
                end
            end
            S_FLUSH: begin
                w_next_state = S_IDLE;
                if (!spm_key_select_valid || abort) begin
                    w_set_error = 1'b1;
                    w_load_err  = 1'b1;
                    w_err_val   = ERR_ABORT;
                end else begin
                    w_set_done = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Word and idle counters. Both restart when CHECK admits a new load.
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_word_cnt <= '0;
            r_idle_cnt <= 8'd0;
        end else if (w_start_load) begin
            r_word_cnt <= '0;
            r_idle_cnt <= 8'd0;
        end else if (w_handshake) begin
            r_word_cnt <= r_word_cnt + 1'b1;
            r_idle_cnt <= 8'd0;
        end else if (r_state == S_LOAD) begin
            r_idle_cnt <= r_idle_cnt + 8'd1;
        end
    end

    // Registered key write port and status pulses. An accepted word is
    // written one cycle after its handshake.
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_write_key <= 1'b0;
            r_key_in    <= 16'h0000;
            r_key_idx   <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_write_key <= w_handshake;
            r_done      <= w_set_done;
            r_error     <= w_set_error;
            if (w_handshake) begin
                r_key_in  <= src.src_data;
                r_key_idx <= r_word_cnt;
            end
            if (w_load_err) begin
                r_err_code <= w_err_val;
            end
        end
    end

    assign src.src_ready = w_src_ready;
    assign write_key     = r_write_key;
    assign key_in        = r_key_in;
    assign key_idx       = r_key_idx;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign error         = r_error;
    assign err_code      = r_err_code;

endmodule

// File: tb/tb_omsp_spm_key_loader.sv
// Self-checking bench for omsp_spm_key_loader. It runs a table of directed
// load scenarios with hand-derived outcomes, a mid-load reset sequence, and
// randomized loads. Every cycle is compared against a transaction-level
// reference model.
module tb_omsp_spm_key_loader;

    localparam int KEY_IDX_SIZE = 3;
    localparam int KEY_WORDS    = 8;
    localparam int TIMEOUT      = 10;
    localparam int MAXC         = 128;
    localparam int TABLE_LEN    = 40;
    localparam int RAND_LEN     = 96;
    localparam int RAND_RUNS    = 12;

    logic                    mclk = 1'b0;
    logic                    puc_rst_n;
    logic                    start;
    logic                    abort;
    logic                    spm_key_select_valid;
    logic                    write_key;
    logic [15:0]             key_in;
    logic [KEY_IDX_SIZE-1:0] key_idx;
    logic                    busy;
    logic                    done;
    logic                    error;
    logic [1:0]              err_code;

    omsp_spm_key_loader_if srcIf();

    omsp_spm_key_loader #(
        .KEY_IDX_SIZE(KEY_IDX_SIZE),
        .KEY_WORDS(KEY_WORDS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .mclk(mclk),
        .puc_rst_n(puc_rst_n),
        .start(start),
        .abort(abort),
        .spm_key_select_valid(spm_key_select_valid),
        .src(srcIf),
        .write_key(write_key),
        .key_in(key_in),
        .key_idx(key_idx),
        .busy(busy),
        .done(done),
        .error(error),
        .err_code(err_code)
    );

    always #5 mclk = ~mclk;

    // Directed scenario record: stimulus shape plus hand-derived outcome.
    // Cycle 0 carries start; -1 means "not used".
    typedef struct {
        int gapStart;
        int gapLen;
        int stopAt;
        int abortAt;
        int deselAt;
        int extraStart;
        int expEnd;
        int expCode;
        int expWrites;
    } vec_t;

    vec_t vecs[9];

    bit                      validA[MAXC];
    bit                      abortA[MAXC];
    bit                      selA[MAXC];
    bit                      startA[MAXC];
    logic [15:0]             keyWords[KEY_WORDS];

    logic [6:0]              expStat[MAXC];
    logic [15:0]             expKin[MAXC];
    logic [KEY_IDX_SIZE-1:0] expKidx[MAXC];
    int                      mCode;
    int                      prevCode;

    int errors = 0;
    int checks = 0;
    int obsEnd, obsCode, obsWrites;

    // Reference model: walks the stimulus at transaction level and predicts
    // every cycle's {write_key, done, error, busy, src_ready, err_code}.
    task automatic buildModel(input int runLen);
        bit wk[MAXC];
        bit rd[MAXC];
        int k, idle, endC, code, codeNow;
        bit fin, isDone;
        for (int c = 0; c < MAXC; c++) begin
            wk[c] = 1'b0;
            rd[c] = 1'b0;
            expKin[c] = 16'h0000;
            expKidx[c] = '0;
        end
        endC = runLen + 10;
        code = 0;
        fin = 1'b0;
        isDone = 1'b0;
        k = 0;
        idle = 0;
        if (!selA[1]) begin
            endC = 2;
            code = 1;
            fin = 1'b1;
        end
        for (int c = 2; c < runLen && !fin; c++) begin
            if (!selA[c] || abortA[c]) begin
                endC = c + 1;
                code = 3;
                fin = 1'b1;
            end else begin
                rd[c] = 1'b1;
                if (validA[c]) begin
                    wk[c + 1] = 1'b1;
                    expKin[c + 1] = keyWords[k];
                    expKidx[c + 1] = KEY_IDX_SIZE'(k);
                    k++;
                    idle = 0;
                    if (k == KEY_WORDS) begin
                        endC = c + 2;
                        fin = 1'b1;
                        if (!selA[c + 1] || abortA[c + 1]) code = 3;
                        else isDone = 1'b1;
                    end
                end else begin
                    idle++;
                    if (idle == TIMEOUT) begin
                        endC = c + 1;
                        code = 2;
                        fin = 1'b1;
                    end
                end
            end
        end
        for (int c = 0; c < runLen; c++) begin
            if (c == 0) codeNow = prevCode;
            else if (c < endC) codeNow = 0;
            else codeNow = code;
            expStat[c] = {wk[c], (isDone && c == endC), (fin && !isDone && c == endC),
                          (c >= 1 && c < endC), rd[c], 2'(codeNow)};
        end
        mCode = code;
    endtask

    // Compare one sampled cycle against the model prediction.
    task automatic checkOutput(input int c);
        logic [6:0] act;
        act = {write_key, done, error, busy, srcIf.src_ready, err_code};
        checks++;
        if (act !== expStat[c]) begin
            errors++;
            $display("[TB] FAIL status cycle %0d: got %b expected %b (wk,done,err,busy,rdy,code)",
                     c, act, expStat[c]);
        end
        if (expStat[c][6]) begin
            checks++;
            if ({key_idx, key_in} !== {expKidx[c], expKin[c]}) begin
                errors++;
                $display("[TB] FAIL keyword cycle %0d: got idx=%0d data=%h expected idx=%0d data=%h",
                         c, key_idx, key_in, expKidx[c], expKin[c]);
            end
        end
    endtask

    // Drive one load scenario cycle by cycle. The source presents its next
    // key word and advances only on a handshake.
    task automatic applyStimulus(input int runLen, output int oEnd, output int oCode,
                                 output int oWrites);
        int srcPtr;
        srcPtr = 0;
        oEnd = -1;
        oCode = 0;
        oWrites = 0;
        buildModel(runLen);
        for (int c = 0; c < runLen; c++) begin
            @(posedge mclk);
            #1;
            start = startA[c];
            abort = abortA[c];
            spm_key_select_valid = selA[c];
            srcIf.src_valid = validA[c];
            srcIf.src_data = (srcPtr < KEY_WORDS) ? keyWords[srcPtr] : 16'hDEAD;
            @(negedge mclk);
            checkOutput(c);
            if (write_key) oWrites++;
            if (oEnd < 0 && c >= 1 && (done || error)) begin
                oEnd = c;
                oCode = int'(err_code);
            end
            if (srcIf.src_valid && srcIf.src_ready) srcPtr++;
        end
        start = 1'b0;
        abort = 1'b0;
        srcIf.src_valid = 1'b0;
        prevCode = mCode;
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Every output at its reset value, including src_ready while valid is high.
    task automatic checkResetValues(input string name);
        logic [26:0] act;
        act = {write_key, done, error, busy, srcIf.src_ready, err_code, key_idx, key_in};
        checks++;
        if (act !== 27'd0) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected 0", name, act);
        end
    endtask

    initial begin
        puc_rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        spm_key_select_valid = 1'b0;
        srcIf.src_valid = 1'b1;
        srcIf.src_data = 16'hFFFF;
        prevCode = 0;

        //               gapS gapL stop abrt desel xStart end code writes
        vecs[0] = '{-1, 0, -1, -1, -1, -1, 11, 0, 8};
        vecs[1] = '{ 6, 3, -1, -1, -1, -1, 14, 0, 8};
        vecs[2] = '{-1, 0, -1, -1,  0, -1,  2, 1, 0};
        vecs[3] = '{-1, 0,  4, -1, -1, -1, 14, 2, 2};
        vecs[4] = '{-1, 0, -1,  6, -1, -1,  7, 3, 4};
        vecs[5] = '{-1, 0, -1, -1,  4, -1,  5, 3, 2};
        vecs[6] = '{-1, 0, -1, 10, -1, -1, 11, 3, 8};
        vecs[7] = '{ 3, 9, -1, -1, -1, -1, 20, 0, 8};
        vecs[8] = '{-1, 0, -1, -1, -1,  5, 11, 0, 8};

        #2;
        checkResetValues("power-on reset");
        @(posedge mclk);
        #3;
        puc_rst_n = 1'b1;
        srcIf.src_valid = 1'b0;

        $display("[TB] directed scenarios");
        for (int w = 0; w < KEY_WORDS; w++) keyWords[w] = 16'((w + 1) * 16'h1111);
        for (int v = 0; v < 9; v++) begin
            for (int c = 0; c < MAXC; c++) begin
                validA[c] = !((vecs[v].gapStart >= 0 && c >= vecs[v].gapStart &&
                               c < vecs[v].gapStart + vecs[v].gapLen) ||
                              (vecs[v].stopAt >= 0 && c >= vecs[v].stopAt));
                selA[c]   = !(vecs[v].deselAt >= 0 && c >= vecs[v].deselAt);
                abortA[c] = (c == vecs[v].abortAt);
                startA[c] = (c == 0) || (c == vecs[v].extraStart);
            end
            applyStimulus(TABLE_LEN, obsEnd, obsCode, obsWrites);
            checkValue($sformatf("vec%0d end cycle", v), obsEnd, vecs[v].expEnd);
            checkValue($sformatf("vec%0d err_code", v), obsCode, vecs[v].expCode);
            checkValue($sformatf("vec%0d writes", v), obsWrites, vecs[v].expWrites);
        end

        $display("[TB] reset in the middle of a load");
        @(posedge mclk);
        #1;
        start = 1'b1;
        spm_key_select_valid = 1'b1;
        srcIf.src_valid = 1'b1;
        srcIf.src_data = 16'hA5A5;
        @(posedge mclk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 4; c++) @(posedge mclk);
        @(negedge mclk);
        checkValue("busy before reset", int'(busy), 1);
        checkValue("key_in before reset", int'(key_in), 16'hA5A5);
        #2;
        puc_rst_n = 1'b0;
        #1;
        checkResetValues("async reset mid-load");
        @(posedge mclk);
        #3;
        puc_rst_n = 1'b1;
        srcIf.src_valid = 1'b0;
        prevCode = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge mclk);
            checkValue("no pulse after reset", int'({done, error, busy}), 0);
        end

        $display("[TB] randomized loads");
        for (int r = 0; r < RAND_RUNS; r++) begin
            int pct;
            int gs;
            int gl;
            int d;
            pct = int'($urandom_range(50, 100));
            for (int w = 0; w < KEY_WORDS; w++) keyWords[w] = 16'($urandom);
            for (int c = 0; c < MAXC; c++) begin
                validA[c] = (int'($urandom_range(0, 99)) < pct);
                abortA[c] = ($urandom_range(0, 63) == 0);
                selA[c]   = 1'b1;
                startA[c] = (c == 0);
            end
            if ($urandom_range(0, 3) == 0) begin
                gs = int'($urandom_range(2, 30));
                gl = int'($urandom_range(8, 12));
                for (int c = gs; c < gs + gl; c++) validA[c] = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin
                d = int'($urandom_range(1, 30));
                for (int c = d; c < MAXC; c++) selA[c] = 1'b0;
            end
            applyStimulus(RAND_LEN, obsEnd, obsCode, obsWrites);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
